dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Arbitrates the single data-memory port between the pipeline MEM stage (CPU) and a debug/loader requester (UI memory inspection and program loading). Sits between the EX_MEM pipeline register outputs and `data_mem`; it drives the memory address, write data and write enable, and returns read data to whichever requester issued the read. The CPU has priority. A starvation counter guarantees the debug port a slot. A lock input gives debug exclusive access while the CPU is halted.

## Interface
Parameters:
- `ADDR_W`, 16: memory address width (byte address; low 2 bits ignored by memory).
- `DATA_W`, 32: data word width.
- `STARVE_MAX`, 8: consecutive denied debug cycles before debug is forced a grant; legal range 1–255.

Ports:
- `clock`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cpu_req`  in  1  MEM stage requests memory this cycle.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  ADDR_W  CPU address.
- `cpu_wdata`  in  DATA_W  CPU write data.
- `cpu_stall`  out  1  CPU request not serviced this cycle; pipeline must hold.
- `cpu_rdata`  out  DATA_W  read data for CPU.
- `cpu_rvalid`  out  1  `cpu_rdata` valid this cycle.
- `dbg_req`  in  1  debug request; held with address/data stable until granted.
- `dbg_we`  in  1  1 = write, 0 = read.
- `dbg_addr`  in  ADDR_W  debug address.
- `dbg_wdata`  in  DATA_W  debug write data.
- `dbg_lock`  in  1  debug has absolute priority (CPU halted, manual clock mode).
- `dbg_gnt`  out  1  debug request accepted this cycle.
- `dbg_rdata`  out  DATA_W  read data for debug.
- `dbg_rvalid`  out  1  `dbg_rdata` valid this cycle.
- `mem_addr`  out  ADDR_W  to `data_mem` address.
- `mem_wdata`  out  DATA_W  to `data_mem` write data.
- `mem_we`  out  1  to `data_mem` write enable.
- `mem_rdata`  in  DATA_W  from `data_mem`; valid one cycle after the read is issued.

## Operation
- Grant is decided combinationally each cycle, from the requests, `dbg_lock` and the registered starve counter `starve`. Priority order:
  - `dbg_lock & dbg_req` → debug.
  - `dbg_req & starve == STARVE_MAX` → debug.
  - `cpu_req & !dbg_lock` → CPU.
  - `dbg_req` → debug.
  - otherwise none.
- `cpu_stall = cpu_req & !cpu_granted`. `dbg_gnt = debug granted`.
- Memory mux:
  - `mem_addr`/`mem_wdata` come from the granted requester; CPU values when none is granted.
  - `mem_we = granted & granted_we`; it is 0 when no grant.
- Read tracking: a registered `rd_owner` {NONE, CPU, DBG} is set to the granted requester on a read grant, else NONE.
  - Next cycle: `cpu_rvalid = (rd_owner == CPU)`, `dbg_rvalid = (rd_owner == DBG)`.
  - Both rdata outputs are `mem_rdata` passed through.
- Starve counter:
  - Increments (saturating at STARVE_MAX) on each cycle with `dbg_req & !dbg_gnt`.
  - Clears to 0 on `dbg_gnt` or `!dbg_req`.
- Writes complete in the grant cycle; no response is generated for writes.

## Timing
- Reset values: `starve = 0`, `rd_owner = NONE`, `cpu_rvalid = dbg_rvalid = 0`, `mem_we = 0` during the reset cycle (grants are forced off). `cpu_stall` and `dbg_gnt` are also 0 during reset.
- Read latency: exactly 1 cycle from grant to rvalid. Back-to-back reads from either port are sustained at 1 per cycle.
- Debug worst-case wait without lock: STARVE_MAX + 1 cycles from the first `dbg_req` to `dbg_gnt`.
- Simultaneous CPU and debug requests with `starve < STARVE_MAX`: CPU wins, debug waits, `starve` increments.
- At the forced debug slot, the CPU stalls for exactly 1 cycle. The CPU then wins the next cycle, because `starve` has cleared.
- `dbg_lock` raised mid-stream: effective the same cycle; the CPU is stalled on every cycle it requests.
- Reset asserted the cycle after a read grant: `rd_owner` clears and the pending rvalid is squashed.
- Requester behaviour is undefined if `dbg_addr`, `dbg_we` or `dbg_wdata` change while `dbg_req` is held ungranted. The arbiter does not register them.

## Configuration
- `DMEM_ARB_PERF_EN` defined:
  - Adds output `stall_count` (16 bits): counts cycles with `cpu_stall = 1`, saturating at 16'hFFFF, cleared by reset.
  - Adds output `dbg_forced` (1 bit): high on cycles where the grant came from starvation.
- `DMEM_ARB_PERF_EN` undefined: neither port exists; no counter logic.

## Test plan
- CPU-only reads to addresses 0x0010 then 0x0014, back-to-back → `mem_addr` = 0x0010, 0x0014 on consecutive cycles; `cpu_rvalid` = 1 on each following cycle with the matching `mem_rdata`; `cpu_stall` = 0 throughout.
- Continuous `cpu_req` plus `dbg_req` read at 0x0040, STARVE_MAX = 8 → `dbg_gnt` on the 9th cycle. `cpu_stall` = 1 on that cycle only. `dbg_rvalid` = 1 the next cycle.
- `dbg_lock` = 1, debug write 0xDEADBEEF to 0x0008 while `cpu_req` = 1 → `mem_we` = 1 with debug data; `cpu_stall` = 1. A later debug read of 0x0008 returns 0xDEADBEEF.
- CPU read granted, reset asserted the next cycle → `cpu_rvalid` = 0; all outputs at reset values.
- `dbg_req` dropped after 5 denied cycles, then re-raised → `starve` restarts from 0; the grant comes after 9 more cycles, not 4.
- With `DMEM_ARB_PERF_EN`, 3 forced debug slots → `stall_count` = 3 and `dbg_forced` pulses 3 times.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data-memory port between the MEM stage (CPU) and a
// debug/loader requester.
//
// Priority: locked debug > starved debug > CPU (unless locked) > debug. A starvation
// counter forces a debug slot after STARVE_MAX consecutive denied cycles. Reads return
// one cycle after the grant; the owner of the outstanding read gets the rvalid strobe.
//
// Ports:
//   clock, reset                 clock and synchronous active-high reset
//   cpu_req/we/addr/wdata        CPU request; cpu_stall when it is not serviced
//   cpu_rdata, cpu_rvalid        CPU read return
//   dbg_req/we/addr/wdata        debug request (held stable until dbg_gnt)
//   dbg_lock                     debug has absolute priority; CPU never granted
//   dbg_gnt, dbg_rdata, dbg_rvalid  debug grant and read return
//   mem_addr/wdata/we, mem_rdata data_mem port (read data one cycle after issue)
//
// Optional build macro DMEM_ARB_PERF_EN adds:
//   stall_count  saturating count of cycles with cpu_stall high
//   dbg_forced   high on cycles where the debug grant came from starvation
module dmem_arbiter #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    input  logic              dbg_lock,
    output logic              dbg_gnt,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
`ifdef DMEM_ARB_PERF_EN
    output logic [15:0]       stall_count,
    output logic              dbg_forced,
`endif
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [7:0] StarveMax = 8'(STARVE_MAX);

    typedef enum logic [1:0] {
        OwnNone,
        OwnCpu,
        OwnDbg
    } rd_owner_e;

    rd_owner_e  rd_owner_q, rd_owner_d;
    logic [7:0] starve_q, starve_d;
    logic       starve_full;
    logic       gnt_cpu, gnt_dbg;

    // Grant decision; forced off while reset is asserted.
    always_comb begin
        starve_full = (starve_q == StarveMax);
        gnt_cpu     = 1'b0;
        gnt_dbg     = 1'b0;
        if (!reset) begin
            if (dbg_lock && dbg_req) begin
                gnt_dbg = 1'b1;
            end else if (dbg_req && starve_full) begin
                gnt_dbg = 1'b1;
            end else if (cpu_req && !dbg_lock) begin
                gnt_cpu = 1'b1;
            end else if (dbg_req) begin
                gnt_dbg = 1'b1;
            end
        end
    end

    // Memory mux: CPU side is the idle default so the address bus follows the pipeline.
    always_comb begin
        cpu_stall = cpu_req && !gnt_cpu && !reset;
        dbg_gnt   = gnt_dbg;
        mem_addr  = gnt_dbg ? dbg_addr  : cpu_addr;
        mem_wdata = gnt_dbg ? dbg_wdata : cpu_wdata;
        mem_we    = (gnt_cpu && cpu_we) || (gnt_dbg && dbg_we);
    end

    // Read return; gating with reset squashes a response pending across reset entry.
    always_comb begin
        cpu_rdata  = mem_rdata;
        dbg_rdata  = mem_rdata;
        cpu_rvalid = !reset && (rd_owner_q == OwnCpu);
        dbg_rvalid = !reset && (rd_owner_q == OwnDbg);
    end

    always_comb begin
        rd_owner_d = OwnNone;
        if (gnt_cpu && !cpu_we) begin
            rd_owner_d = OwnCpu;
        end else if (gnt_dbg && !dbg_we) begin
            rd_owner_d = OwnDbg;
        end
    end

    always_comb begin
        starve_d = 8'd0;
        if (dbg_req && !gnt_dbg) begin
            starve_d = starve_full ? starve_q : starve_q + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_owner_q <= OwnNone;
            starve_q   <= 8'd0;
        end else begin
            rd_owner_q <= rd_owner_d;
            starve_q   <= starve_d;
        end
    end

`ifdef DMEM_ARB_PERF_EN
    logic [15:0] stall_count_q, stall_count_d;

    always_comb begin
        // A lock grant takes precedence, so it is never counted as a starvation slot.
        dbg_forced    = !reset && dbg_req && starve_full && !dbg_lock;
        stall_count_d = stall_count_q;
        if (cpu_stall && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
        stall_count = stall_count_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_count_q <= 16'd0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: table of single-cycle vectors plus hand-written
// multi-cycle sequences; read responses are checked through a scoreboard queue.
module tb_dmem_arbiter;

    localparam logic N = 1'b0;
    localparam logic Y = 1'b1;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic        cpu_stall, cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        dbg_req = 1'b0, dbg_we = 1'b0, dbg_lock = 1'b0;
    logic [15:0] dbg_addr = '0;
    logic [31:0] dbg_wdata = '0;
    logic        dbg_gnt, dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;
`ifdef DMEM_ARB_PERF_EN
    logic [15:0] stall_count;
    logic        dbg_forced;
    int          forced_pulses = 0;
`endif

    always #5 clock = ~clock;

    dmem_arbiter #(
        .ADDR_W    (16),
        .DATA_W    (32),
        .STARVE_MAX(8)
    ) u_dut (
        .clock      (clock),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_stall  (cpu_stall),
        .cpu_rdata  (cpu_rdata),
        .cpu_rvalid (cpu_rvalid),
        .dbg_req    (dbg_req),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_lock   (dbg_lock),
        .dbg_gnt    (dbg_gnt),
        .dbg_rdata  (dbg_rdata),
        .dbg_rvalid (dbg_rvalid),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
`ifdef DMEM_ARB_PERF_EN
        .stall_count(stall_count),
        .dbg_forced (dbg_forced),
`endif
        .mem_rdata  (mem_rdata)
    );

    function automatic logic [31:0] init_val(input int i);
        return 32'hA500_0000 | 32'(i);
    endfunction

    // data_mem stand-in: synchronous write, registered read data.
    logic [31:0] mem [64];
    logic        mem_ready = 1'b0;
    always @(posedge clock) begin
        if (!mem_ready) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
            mem_ready <= 1'b1;
        end else begin
            if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
            mem_rdata <= mem[mem_addr[7:2]];
        end
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic [31:0] ref_mem [64];

    typedef struct {
        logic        creq, cwe;
        logic [15:0] caddr;
        logic [31:0] cwd;
        logic        dreq, dwe;
        logic [15:0] daddr;
        logic [31:0] dwd;
        logic        lock;
        logic        e_stall, e_gnt;
        logic [15:0] e_addr;
        logic        e_we;
        logic [31:0] e_wdata;
    } vec_t;

    typedef struct {
        bit          is_dbg;
        logic [31:0] data;
        int          due;
    } rd_exp_t;

    rd_exp_t sb[$];
    int      n_tests = 0;
    int      n_fail  = 0;

    localparam vec_t Idle = '{N, N, 16'h0, 32'h0, N, N, 16'h0, 32'h0, N,
                              N, N, 16'h0, N, 32'h0};

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    task automatic check_reads(input string nm);
        logic        exp_c, exp_d;
        logic [31:0] dat_c, dat_d;
        rd_exp_t     e;
        exp_c = N; exp_d = N; dat_c = '0; dat_d = '0;
        while (sb.size() != 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            if (!reset) begin
                if (e.is_dbg) begin exp_d = Y; dat_d = e.data; end
                else          begin exp_c = Y; dat_c = e.data; end
            end
        end
        chk({nm, " cpu_rvalid"}, 32'(cpu_rvalid), 32'(exp_c));
        chk({nm, " dbg_rvalid"}, 32'(dbg_rvalid), 32'(exp_d));
        if (exp_c) chk({nm, " cpu_rdata"}, cpu_rdata, dat_c);
        if (exp_d) chk({nm, " dbg_rdata"}, dbg_rdata, dat_d);
    endtask

    // Drive one cycle of inputs, check outputs mid-cycle, record expected read returns.
    task automatic step(input string nm, input vec_t v);
        rd_exp_t e;
        cpu_req = v.creq; cpu_we = v.cwe; cpu_addr = v.caddr; cpu_wdata = v.cwd;
        dbg_req = v.dreq; dbg_we = v.dwe; dbg_addr = v.daddr; dbg_wdata = v.dwd;
        dbg_lock = v.lock;
        @(negedge clock);
        check_reads(nm);
        chk({nm, " cpu_stall"}, 32'(cpu_stall), 32'(v.e_stall));
        chk({nm, " dbg_gnt"},   32'(dbg_gnt),   32'(v.e_gnt));
        chk({nm, " mem_addr"},  32'(mem_addr),  32'(v.e_addr));
        chk({nm, " mem_we"},    32'(mem_we),    32'(v.e_we));
        chk({nm, " mem_wdata"}, mem_wdata,      v.e_wdata);
        if (!reset && v.creq && !v.e_stall) begin
            if (v.cwe) ref_mem[v.caddr[7:2]] = v.cwd;
            else begin
                e = '{1'b0, ref_mem[v.caddr[7:2]], cyc + 1};
                sb.push_back(e);
            end
        end
        if (!reset && v.e_gnt) begin
            if (v.dwe) ref_mem[v.daddr[7:2]] = v.dwd;
            else begin
                e = '{1'b1, ref_mem[v.daddr[7:2]], cyc + 1};
                sb.push_back(e);
            end
        end
`ifdef DMEM_ARB_PERF_EN
        if (dbg_forced) forced_pulses++;
`endif
        @(posedge clock);
        #1;
    endtask

    // CPU reads every cycle while debug waits for its forced slot on the 9th cycle.
    task automatic starve_round(input string nm);
        vec_t v;
        for (int k = 1; k <= 9; k++) begin
            v = '{Y, N, 16'(k * 4), 32'h0, Y, N, 16'h0040, 32'h0, N,
                  N, N, 16'(k * 4), N, 32'h0};
            if (k == 9) begin
                v.e_stall = Y; v.e_gnt = Y; v.e_addr = 16'h0040;
            end
            step($sformatf("%s c%0d", nm, k), v);
        end
        // Counter cleared by the grant: CPU wins again even with debug still asking.
        step({nm, " after"}, '{Y, N, 16'h0050, 32'h0, Y, N, 16'h0040, 32'h0, N,
                               N, N, 16'h0050, N, 32'h0});
        step({nm, " idle"}, Idle);
    endtask

    vec_t tbl[13];

    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);

        tbl[0]  = '{Y, N, 16'h0010, 32'h0, N, N, 16'h0, 32'h0, N,
                    N, N, 16'h0010, N, 32'h0};
        tbl[1]  = '{Y, N, 16'h0014, 32'h0, N, N, 16'h0, 32'h0, N,
                    N, N, 16'h0014, N, 32'h0};
        tbl[2]  = '{Y, Y, 16'h0020, 32'h1111_2222, N, N, 16'h0, 32'h0, N,
                    N, N, 16'h0020, Y, 32'h1111_2222};
        tbl[3]  = '{N, N, 16'h0030, 32'h33, N, N, 16'h0, 32'h0, N,
                    N, N, 16'h0030, N, 32'h33};
        tbl[4]  = '{N, N, 16'h0, 32'h0, Y, N, 16'h0040, 32'h0, N,
                    N, Y, 16'h0040, N, 32'h0};
        tbl[5]  = '{N, N, 16'h0, 32'h0, Y, Y, 16'h0044, 32'hCAFE_F00D, N,
                    N, Y, 16'h0044, Y, 32'hCAFE_F00D};
        tbl[6]  = '{Y, N, 16'h0010, 32'h0, Y, N, 16'h0048, 32'h0, N,
                    N, N, 16'h0010, N, 32'h0};
        tbl[7]  = '{Y, Y, 16'h0024, 32'h55, Y, N, 16'h0048, 32'h0, N,
                    N, N, 16'h0024, Y, 32'h55};
        tbl[8]  = '{N, N, 16'h0, 32'h0, Y, N, 16'h0048, 32'h0, N,
                    N, Y, 16'h0048, N, 32'h0};
        tbl[9]  = '{Y, N, 16'h0010, 32'h0, Y, N, 16'h0020, 32'h0, Y,
                    Y, Y, 16'h0020, N, 32'h0};
        tbl[10] = '{Y, N, 16'h0010, 32'h0, N, N, 16'h0, 32'h0, Y,
                    Y, N, 16'h0010, N, 32'h0};
        tbl[11] = '{N, N, 16'h0, 32'h0, Y, N, 16'h0044, 32'h0, N,
                    N, Y, 16'h0044, N, 32'h0};
        tbl[12] = Idle;

        // Reset: outputs quiet, and a CPU write during reset is not issued.
        step("rst0", Idle);
        step("rst_we", '{Y, Y, 16'h0004, 32'h77, N, N, 16'h0, 32'h0, N,
                         N, N, 16'h0004, N, 32'h77});
        reset = 1'b0;
        step("post_rst", Idle);

        foreach (tbl[i]) step($sformatf("vec%0d", i), tbl[i]);

        starve_round("starve");

        // Debug drops after 5 denied cycles; re-raise must wait a full 9 cycles.
        for (int k = 1; k <= 5; k++)
            step($sformatf("drop d%0d", k), '{Y, N, 16'h0018, 32'h0, Y, N, 16'h0040, 32'h0,
                                               N, N, N, 16'h0018, N, 32'h0});
        step("drop gap", '{Y, N, 16'h001C, 32'h0, N, N, 16'h0, 32'h0, N,
                           N, N, 16'h001C, N, 32'h0});
        for (int k = 1; k <= 9; k++) begin
            if (k < 9)
                step($sformatf("rera c%0d", k), '{Y, N, 16'h0018, 32'h0, Y, N, 16'h0040,
                                                   32'h0, N, N, N, 16'h0018, N, 32'h0});
            else
                step("rera c9", '{Y, N, 16'h0018, 32'h0, Y, N, 16'h0040, 32'h0, N,
                                  Y, Y, 16'h0040, N, 32'h0});
        end
        step("rera idle", Idle);

        // Locked debug write beats the CPU, then reads the value back.
        step("lock wr", '{Y, N, 16'h0010, 32'h0, Y, Y, 16'h0008, 32'hDEAD_BEEF, Y,
                          Y, Y, 16'h0008, Y, 32'hDEAD_BEEF});
        step("lock rd", '{Y, N, 16'h0010, 32'h0, Y, N, 16'h0008, 32'h0, Y,
                          Y, Y, 16'h0008, N, 32'h0});
        step("lock idle", Idle);
        chk("lock readback model", ref_mem[2], 32'hDEAD_BEEF);

        // Reset the cycle after a CPU read grant squashes the response.
        step("rr grant", '{Y, N, 16'h0014, 32'h0, N, N, 16'h0, 32'h0, N,
                           N, N, 16'h0014, N, 32'h0});
        reset = 1'b1;
        step("rr reset", Idle);
        reset = 1'b0;
        step("rr after", Idle);

`ifdef DMEM_ARB_PERF_EN
        reset = 1'b1;
        step("perf rst", Idle);
        reset = 1'b0;
        forced_pulses = 0;
        step("perf idle", Idle);
        for (int r = 0; r < 3; r++) starve_round($sformatf("perf r%0d", r));
        chk("stall_count", 32'(stall_count), 32'd3);
        chk("dbg_forced pulses", 32'(forced_pulses), 32'd3);
`endif

        chk("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
